// File: rtl/trace_event_counters_if.sv
// Trace-event counter bus: event inputs, run/clear/snapshot controls and the shadow read port.
interface trace_event_counters_if #(
  parameter int unsigned NUM_EVENTS = 26
);
  logic [NUM_EVENTS-1:0] events;
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  snapshot;
  logic                  rd_req;
  logic [4:0]            rd_idx;
  logic                  rd_valid;
  logic [31:0]           rd_data;
  logic [NUM_EVENTS-1:0] overflow;
  logic                  running;

  modport master (
    output events, start, stop, clear, snapshot, rd_req, rd_idx,
    input  rd_valid, rd_data, overflow, running
  );

  modport slave (
    input  events, start, stop, clear, snapshot, rd_req, rd_idx,
    output rd_valid, rd_data, overflow, running
  );
endinterface

// File: rtl/trace_event_counters.sv
// Per-event trace counters with atomic snapshot shadows and a one-cycle read port.
// CVA5_TRACE_CYCLE_COUNTER_EN adds a run-cycle counter at index NUM_EVENTS.
module trace_event_counters #(
  parameter int unsigned NUM_EVENTS = 26,
  parameter int unsigned COUNTER_W  = 32,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  trace_event_counters_if.slave  bus
);

`ifdef CVA5_TRACE_CYCLE_COUNTER_EN
  localparam int unsigned NUM_CNT = NUM_EVENTS + 1;
`else
  localparam int unsigned NUM_CNT = NUM_EVENTS;
`endif

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t               state, state_next;
  logic                 running_q;
  logic [NUM_CNT-1:0]   ev_in, ev_q, ov_q, ov_hit;
  logic [COUNTER_W-1:0] cnt_q    [NUM_CNT];
  logic [COUNTER_W-1:0] cnt_inc  [NUM_CNT];
  logic [COUNTER_W-1:0] shadow_q [NUM_CNT];
  logic                 rd_valid_q;
  logic [31:0]          rd_data_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start && !bus.stop) state_next = RUN;
      RUN:     if (bus.stop) state_next = HALT;
      HALT:    if (bus.start && !bus.stop) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
`ifdef CVA5_TRACE_CYCLE_COUNTER_EN
    ev_in = {running_q, bus.events & {NUM_EVENTS{running_q}}};
`else
    ev_in = bus.events & {NUM_EVENTS{running_q}};
`endif
  end

  // Overflow fires on any increment attempted at all-ones, in both wrap and saturate modes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      ov_hit[i]  = ev_q[i] && (cnt_q[i] == '1);
      cnt_inc[i] = cnt_q[i];
      if (ev_q[i] && !((SATURATE != 0) && ov_hit[i]))
        cnt_inc[i] = cnt_q[i] + COUNTER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      running_q  <= 1'b0;
      ev_q       <= '0;
      ov_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state      <= state_next;
      running_q  <= (state_next == RUN);
      ev_q       <= bus.clear ? '0 : ev_in;
      ov_q       <= bus.clear ? '0 : (ov_q | ov_hit);
      // Shadows take the post-increment, pre-clear value so snapshot+clear loses nothing.
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= bus.clear ? '0 : cnt_inc[i];
        if (bus.snapshot) shadow_q[i] <= cnt_inc[i];
      end
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        if (32'(bus.rd_idx) < NUM_CNT) rd_data_q <= 32'(shadow_q[bus.rd_idx]);
        else                           rd_data_q <= '0;
      end
    end
  end

  assign bus.running  = running_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.overflow = ov_q[NUM_EVENTS-1:0];

endmodule

// File: tb/tb_trace_event_counters.sv
// Drives three counter configurations (32-bit wrap, 4-bit wrap, 4-bit saturate) from one stimulus
// stream and compares them each cycle against an unbounded-count reference model.
module tb_trace_event_counters;
  localparam int NE = 26;
`ifdef CVA5_TRACE_CYCLE_COUNTER_EN
  localparam int NC      = 27;
  localparam int CYC_EXP = 100;
`else
  localparam int NC      = 26;
  localparam int CYC_EXP = 0;
`endif
  localparam int ALU_IDX  = 15;
  localparam int LOAD_IDX = 13;
  localparam int BC_IDX   = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          t_rst, t_start, t_stop, t_clr, t_snap, t_rd_req;
  logic [NE-1:0] t_ev;
  logic [4:0]    t_rd_idx;

  logic          obs_valid [3];
  logic [31:0]   obs_data  [3];
  logic [NE-1:0] obs_ov    [3];
  logic          obs_run   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    trace_event_counters_if #(.NUM_EVENTS(NE)) bus ();
    assign bus.events   = t_ev;
    assign bus.start    = t_start;
    assign bus.stop     = t_stop;
    assign bus.clear    = t_clr;
    assign bus.snapshot = t_snap;
    assign bus.rd_req   = t_rd_req;
    assign bus.rd_idx   = t_rd_idx;
    assign obs_valid[g] = bus.rd_valid;
    assign obs_data[g]  = bus.rd_data;
    assign obs_ov[g]    = bus.overflow;
    assign obs_run[g]   = bus.running;
    trace_event_counters #(
      .NUM_EVENTS(NE),
      .COUNTER_W ((g == 0) ? 32 : 4),
      .SATURATE  ((g == 2) ? 1 : 0)
    ) u_dut (
      .clk(clk),
      .rst(t_rst),
      .bus(bus)
    );
  end

  // Reference model: true event totals since the last clear; width/saturation applied on observation.
  longint unsigned tot [27];
  longint unsigned shd [27];
  logic [26:0]     s1_m;
  int              st_m;
  bit              run_m, rdv_m;
  longint unsigned rdt_m;
  int nvec = 0;
  int nerr = 0;

  function automatic longint unsigned cmax(int g);
    return (64'd1 << ((g == 0) ? 32 : 4)) - 64'd1;
  endfunction

  function automatic logic [31:0] fold(longint unsigned t, int g);
    if (g == 2) return 32'((t > cmax(g)) ? cmax(g) : t);
    return 32'(t & cmax(g));
  endfunction

  function automatic logic [31:0] exp_ov(int g);
    logic [31:0] r = '0;
    for (int i = 0; i < NE; i++) r[i] = (tot[i] > cmax(g));
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("running[%0d]", g), 32'(obs_run[g]), 32'(run_m));
      chk($sformatf("rd_valid[%0d]", g), 32'(obs_valid[g]), 32'(rdv_m));
      if (rdv_m) chk($sformatf("rd_data[%0d]", g), obs_data[g], fold(rdt_m, g));
      chk($sformatf("overflow[%0d]", g), 32'(obs_ov[g]), exp_ov(g));
    end
  endtask

  task automatic cycle();
    longint unsigned upd [27];
    @(posedge clk);
    if (t_rst) begin
      for (int i = 0; i < 27; i++) begin tot[i] = 0; shd[i] = 0; end
      s1_m = '0; st_m = 0; run_m = 0; rdv_m = 0; rdt_m = 0;
    end else begin
      for (int i = 0; i < 27; i++) upd[i] = tot[i] + 64'(s1_m[i]);
      rdv_m = t_rd_req;
      if (t_rd_req) rdt_m = (int'(t_rd_idx) < NC) ? shd[t_rd_idx] : 0;
      if (t_snap) for (int i = 0; i < 27; i++) shd[i] = upd[i];
      for (int i = 0; i < 27; i++) tot[i] = t_clr ? 0 : upd[i];
      if (t_clr) s1_m = '0;
      else begin
        s1_m[NE-1:0] = t_ev & {NE{run_m}};
        s1_m[26]     = (NC == 27) && run_m;
      end
      if (t_stop) begin
        if (st_m == 1) st_m = 2;
      end else if (t_start) st_m = 1;
      run_m = (st_m == 1);
    end
    #1;
    t_start = 0; t_stop = 0; t_clr = 0; t_snap = 0; t_rd_req = 0;
    check_all();
  endtask

  task automatic rd(int idx);
    t_rd_req = 1'b1;
    t_rd_idx = 5'(idx);
    cycle();
  endtask

  initial begin
    t_rst = 1; t_start = 0; t_stop = 0; t_clr = 0; t_snap = 0; t_rd_req = 0;
    t_ev = '0; t_rd_idx = '0;
    cycle(); cycle();
    for (int g = 0; g < 3; g++) chk("reset_rd_data", obs_data[g], 32'd0);
    t_rst = 0;

    // Events while IDLE are ignored.
    repeat (6) begin t_ev = NE'($urandom); cycle(); end
    t_ev = '0;

    // Ten alu_op cycles.
    t_start = 1; cycle();
    t_ev[ALU_IDX] = 1'b1; repeat (10) cycle();
    t_ev = '0; t_stop = 1; cycle();
    t_snap = 1; cycle();
    rd(ALU_IDX);
    for (int g = 0; g < 3; g++) begin
      chk("alu_op_count", obs_data[g], 32'd10);
      chk("alu_running", 32'(obs_run[g]), 32'd0);
    end

    // Seventeen load_op: 32-bit -> 17, 4-bit wrap -> 1, 4-bit saturate -> 15.
    t_clr = 1; cycle();
    t_start = 1; cycle();
    t_ev[LOAD_IDX] = 1'b1; repeat (17) cycle();
    t_ev = '0; t_stop = 1; cycle();
    t_snap = 1; cycle();
    rd(LOAD_IDX);
    chk("load_w32", obs_data[0], 32'd17);
    chk("load_w4_wrap", obs_data[1], 32'd1);
    chk("load_w4_sat", obs_data[2], 32'd15);
    chk("load_ov_w32", 32'(obs_ov[0][LOAD_IDX]), 32'd0);
    chk("load_ov_wrap", 32'(obs_ov[1][LOAD_IDX]), 32'd1);
    chk("load_ov_sat", 32'(obs_ov[2][LOAD_IDX]), 32'd1);

    // Clear while all events held high.
    t_start = 1; cycle();
    t_ev = '1; repeat (19) cycle();
    t_clr = 1; cycle();
    t_snap = 1; cycle();
    t_snap = 1; rd(5);
    for (int g = 0; g < 3; g++) chk("clear_live_zero", obs_data[g], 32'd0);
    rd(5);
    for (int g = 0; g < 3; g++) chk("clear_resume", obs_data[g], 32'd1);

    // Snapshot and clear together after five branch_correct events.
    t_ev = '0; t_clr = 1; cycle();
    t_ev[BC_IDX] = 1'b1; repeat (5) cycle();
    t_ev = '0; t_snap = 1; t_clr = 1; cycle();
    rd(BC_IDX);
    for (int g = 0; g < 3; g++) chk("snap_clear_shadow", obs_data[g], 32'd5);
    t_snap = 1; cycle();
    rd(BC_IDX);
    for (int g = 0; g < 3; g++) chk("snap_clear_live", obs_data[g], 32'd0);

    // Out-of-range index.
    rd(26);
    rd(31);
    for (int g = 0; g < 3; g++) begin
      chk("oob_valid", 32'(obs_valid[g]), 32'd1);
      chk("oob_data", obs_data[g], 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      t_ev     = NE'($urandom);
      t_snap   = ($urandom_range(0, 7) == 0);
      t_rd_req = $urandom_range(0, 1);
      t_rd_idx = 5'($urandom_range(0, 31));
      t_clr    = ($urandom_range(0, 39) == 0);
      t_stop   = ($urandom_range(0, 29) == 0);
      t_start  = ($urandom_range(0, 19) == 0);
      cycle();
    end
    t_ev = '0;

    // Cycle counter over 100 running cycles.
    t_stop = 1; cycle();
    t_clr = 1; cycle();
    t_start = 1; cycle();
    repeat (99) cycle();
    t_stop = 1; cycle();
    t_snap = 1; cycle();
    rd(26);
    chk("cycle_counter", obs_data[0], 32'(CYC_EXP));

    // Reset mid-RUN with a read in the same cycle.
    t_start = 1; cycle();
    repeat (8) begin t_ev = NE'($urandom); cycle(); end
    t_snap = 1; cycle();
    t_rd_req = 1; t_rd_idx = 5'(3); t_rst = 1; cycle();
    for (int g = 0; g < 3; g++) begin
      chk("rst_rd_valid", 32'(obs_valid[g]), 32'd0);
      chk("rst_running", 32'(obs_run[g]), 32'd0);
      chk("rst_overflow", 32'(obs_ov[g]), 32'd0);
      chk("rst_rd_data", obs_data[g], 32'd0);
    end
    t_rst = 0; t_ev = '1;
    repeat (5) cycle();
    t_snap = 1; cycle();
    for (int i = 0; i < 27; i++) begin
      rd(i);
      chk($sformatf("post_rst_idx%0d", i), obs_data[0], 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
